// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and helpers for the LC-3b fetch/prefetch front end.
package fetch_prefetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  // Fetch FSM encoding (legacy-compatible constants)
  typedef logic [1:0] fetch_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } fetch_entry_t;

  // Next sequential instruction address; wraps modulo 2^16.
  function automatic lc3b_word pc_next(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

  // Instructions are word aligned, so bit 0 of any target is forced low.
  function automatic lc3b_word word_align(input lc3b_word addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO with flush, combinational head and occupancy.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  input  logic                         flush,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage needs no reset: nothing reads a slot before it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // The fetch FSM only issues a request with room reserved, so a full push is a design bug.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) assert (count != CW'(DEPTH));
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// LC-3b fetch front end: sequential prefetch into a DEPTH-entry queue with redirect/flush.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no read outstanding; launches a request when the queue has room
//   ST_FETCH | read of req_addr outstanding, response will be queued
//   ST_DRAIN | read of stale req_addr outstanding after a redirect; response dropped
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state;
  lc3b_word      fetch_pc;
  lc3b_word      req_addr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign push      = (state == ST_FETCH) && imem_resp && !redirect;
  assign pop       = ir_valid && ir_ready && !redirect;
  assign push_data = '{pc: req_addr, ir: imem_rdata};

  // Occupancy once this cycle's push/pop land; decides whether to chain the next read.
  always_comb begin
    count_after = count;
    if (push && !pop)      count_after = count + CW'(1);
    else if (pop && !push) count_after = count - CW'(1);
  end

  // Fetch sequencer: at most one read in flight, address only ever from req_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
          end else if (count < CW'(DEPTH)) begin
            req_addr <= fetch_pc;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_resp) begin
            if (redirect) begin
              fetch_pc <= word_align(redirect_pc);
              state    <= ST_IDLE;
            end else begin
              fetch_pc <= pc_next(req_addr);
              if (count_after < CW'(DEPTH)) req_addr <= pc_next(req_addr);
              else                          state    <= ST_IDLE;
            end
          end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Memory cannot abort: keep the stale request up until it completes.
          if (redirect)  fetch_pc <= word_align(redirect_pc);
          if (imem_resp) state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign imem_read    = (state != ST_IDLE);
  assign imem_address = req_addr;
  assign ir_valid     = (count != '0);
  assign ir_out       = ir_valid ? head.ir : 16'h0000;
  assign pc_out       = ir_valid ? head.pc : 16'h0000;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with a latency-programmable memory model.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_out;
  logic [15:0] pc_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb [$];
  int          lat;
  logic        spur_req;
  int          resp_cnt;
  logic [15:0] last_addr;

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .ir_out       (ir_out),
    .pc_out       (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a);
    sb.push_back({a, memf(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ir_ready = 1'b0;
    redirect = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 80 && sb.size() != 0; k++) step();
    ir_ready = 1'b0;
    chk(name, sb.size(), 0);
  endtask

  // Memory model: responds after lat cycles of imem_read, checks address stability.
  initial begin
    logic [15:0] req_start;
    int          wcnt;
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    resp_cnt   = 0;
    last_addr  = 16'h0000;
    wcnt       = 0;
    req_start  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_resp = 1'b0;
        wcnt      = 0;
      end else if (spur_req && !imem_read) begin
        imem_resp  = 1'b1;
        imem_rdata = 16'hDEAD;
      end else if (imem_read) begin
        if (wcnt == 0) req_start = imem_address;
        wcnt++;
        if (wcnt >= lat) begin
          chk("addr_stable", imem_address, req_start);
          imem_resp  = 1'b1;
          imem_rdata = memf(imem_address);
          last_addr  = imem_address;
          resp_cnt++;
          wcnt = 0;
        end else begin
          imem_resp = 1'b0;
        end
      end else begin
        imem_resp = 1'b0;
        wcnt      = 0;
      end
    end
  end

  // Monitor: every accepted head is compared against the oldest expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ir_valid && ir_ready && !redirect) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h expected none", {pc_out, ir_out});
        end else begin
          e = sb.pop_front();
          chk("head_pair", {pc_out, ir_out}, e);
        end
      end
    end
  end

  initial begin
    int t_first;
    int t_last;
    int base;

    rst_n       = 1'b1;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    lat         = 1;
    spur_req    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_imem_read", imem_read, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_out", ir_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_imem_address", imem_address, 0);

    // Streaming with 1-cycle memory: one instruction per cycle.
    for (int i = 0; i < 8; i++) push_exp(16'(2 * i));
    do_reset();
    ir_ready = 1'b1;
    t_first  = -1;
    t_last   = -1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      step();
      if (t_first < 0 && sb.size() < 8) t_first = k;
      if (sb.size() == 0) t_last = k;
    end
    ir_ready = 1'b0;
    chk("stream_done", sb.size(), 0);
    chk("stream_gap", t_last - t_first, 7);

    // Decode stalled: exactly DEPTH reads, then one pop frees a slot for 0008.
    do_reset();
    base = resp_cnt;
    for (int k = 0; k < 10; k++) step();
    chk("full_reads", resp_cnt - base, 4);
    chk("full_last_addr", last_addr, 16'h0006);
    chk("full_no_read", imem_read, 0);
    chk("full_valid", ir_valid, 1);
    push_exp(16'h0000);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("refill_reads", resp_cnt - base, 5);
    chk("refill_addr", last_addr, 16'h0008);
    chk("refill_no_read", imem_read, 0);

    // Redirect to 3001 while the 0004 read is outstanding (3-cycle memory).
    lat = 3;
    do_reset();
    push_exp(16'h0000);
    push_exp(16'h0002);
    push_exp(16'h3000);
    push_exp(16'h3002);
    ir_ready = 1'b1;
    for (int k = 0; k < 40 && !(imem_read && imem_address == 16'h0004); k++) step();
    chk("t3_reach_0004", imem_address, 16'h0004);
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h3001;
    step();
    redirect = 1'b0;
    chk("t3_drain_read", imem_read, 1);
    chk("t3_drain_addr", imem_address, 16'h0004);
    chk("t3_flushed", ir_valid, 0);
    for (int k = 0; k < 20 && !(imem_read && imem_address == 16'h3000); k++) step();
    chk("t3_next_addr", imem_address, 16'h3000);
    chk("t3_valid_low", ir_valid, 0);
    wait_empty("t3_drained");

    // Redirect coinciding with imem_resp and ir_ready: drop data, no pop.
    do_reset();
    for (int k = 0; k < 40 && !(imem_read && imem_address == 16'h0002); k++) step();
    chk("t4_reach_0002", imem_address, 16'h0002);
    step();
    step();
    chk("t4_valid_before", ir_valid, 1);
    push_exp(16'h4000);
    push_exp(16'h4002);
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    ir_ready    = 1'b1;
    step();
    redirect = 1'b0;
    chk("t4_empty", ir_valid, 0);
    chk("t4_idle", imem_read, 0);
    step();
    chk("t4_read", imem_read, 1);
    chk("t4_addr", imem_address, 16'h4000);
    wait_empty("t4_drained");

    // Wrap through the top of memory; redirect in IDLE has 1-cycle latency.
    lat = 1;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    push_exp(16'hFFFC);
    push_exp(16'hFFFE);
    push_exp(16'h0000);
    push_exp(16'h0002);
    ir_ready = 1'b1;
    step();
    redirect = 1'b0;
    chk("t5_no_read", imem_read, 0);
    step();
    chk("t5_read", imem_read, 1);
    chk("t5_addr", imem_address, 16'hFFFC);
    wait_empty("t5_drained");

    // Asynchronous reset mid-FETCH, then a stray response while imem_read is low.
    lat         = 3;
    redirect    = 1'b1;
    redirect_pc = 16'h5000;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 60 && !(imem_read && imem_address == 16'h5002); k++) step();
    chk("t6_reach_5002", imem_address, 16'h5002);
    chk("t6_valid", ir_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_read_drop", imem_read, 0);
    chk("t6_valid_drop", ir_valid, 0);
    step();
    rst_n    = 1'b1;
    spur_req = 1'b1;
    lat      = 1;
    push_exp(16'h0000);
    push_exp(16'h0002);
    step();
    spur_req = 1'b0;
    chk("t6_spur_ignored", ir_valid, 0);
    chk("t6_restart_read", imem_read, 1);
    chk("t6_restart_addr", imem_address, 16'h0000);
    ir_ready = 1'b1;
    wait_empty("t6_drained");

    step();
    step();
    chk("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
